// File: rtl/dff_ram_bw.sv
// Flop-based single-port RAM with per-lane write mask and a hardware clear engine.
// Latency: reads return rdata/rvalid one cycle after the request; writes land at the request edge.
// Backpressure: ready=0 while the clear engine runs; accesses presented then are dropped.
module dff_ram_bw #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 72,
    parameter int LANE  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    wr,
    input  logic [ADDR_W-1:0]       address,
    input  logic [WIDTH/LANE-1:0]   wmask,
    input  logic [WIDTH-1:0]        wdata,
    input  logic                    clr,
    output logic [WIDTH-1:0]        rdata,
    output logic                    rvalid,
    output logic                    rerr,
    output logic                    ready
);

    localparam int NLANE = WIDTH / LANE;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    // One extra bit so DEPTH itself is representable when it is a power of two.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   ptr;
    logic                clear_wr;
    logic                do_wr;
    logic                do_rd;
    logic                in_range;
    logic [WIDTH-1:0]    rd_word;
    logic [WIDTH-1:0]    mem [DEPTH];

    // Out-of-range addresses only exist when DEPTH is not a power of two.
    assign in_range = ({1'b0, address} < DEPTH_EXT);

    // State register: reset always (re)starts the clear from word 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: clear runs to the last word; clr in IDLE restarts it, clr in CLEAR is ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: if (ptr == LAST_ADDR) state_nxt = S_IDLE;
            S_IDLE:  if (clr)              state_nxt = S_CLEAR;
            default:                       state_nxt = S_CLEAR;
        endcase
    end

    // Outputs/strobes: clr wins over any access presented in the same cycle.
    always_comb begin
        ready    = (state == S_IDLE);
        clear_wr = (state == S_CLEAR);
        do_wr    = (state == S_IDLE) && !clr && !en && !wr;
        do_rd    = (state == S_IDLE) && !clr && !en &&  wr;
    end

    // Clear pointer: walks every word once per clear, parks at 0 otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (clear_wr) begin
            if (ptr == LAST_ADDR) begin
                ptr <= '0;
            end else begin
                ptr <= ptr + ADDR_W'(1);
            end
        end
    end

    // Storage: no reset, contents defined by the clear engine or masked writes.
    always_ff @(posedge clk) begin
        for (int w = 0; w < DEPTH; w++) begin
            if (clear_wr && (ptr == ADDR_W'(w))) begin
                mem[w] <= '0;
            end else if (do_wr && in_range && (address == ADDR_W'(w))) begin
                for (int i = 0; i < NLANE; i++) begin
                    if (wmask[i]) begin
                        mem[w][i*LANE +: LANE] <= wdata[i*LANE +: LANE];
                    end
                end
            end
        end
    end

    // Read mux built by compare so an out-of-range address never indexes the array.
    always_comb begin
        rd_word = '0;
        for (int w = 0; w < DEPTH; w++) begin
            if (address == ADDR_W'(w)) begin
                rd_word = mem[w];
            end
        end
    end

    // Registered read port: rdata holds between reads, strobes last one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
            rerr   <= 1'b0;
        end else begin
            rvalid <= do_rd;
            rerr   <= do_rd && !in_range;
            if (do_rd) begin
                rdata <= in_range ? rd_word : '0;
            end
        end
    end

endmodule

// File: tb/tb_dff_ram_bw.sv
module tb_dff_ram_bw;

    logic        clk;
    logic        rst;
    logic        en;
    logic        wr;
    logic [1:0]  address;
    logic [8:0]  wmask;
    logic [71:0] wdata;
    logic        clr;

    logic [71:0] rdata4, rdata3;
    logic        rvalid4, rvalid3, rerr4, rerr3, ready4, ready3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [71:0] data;
        logic        err;
    } exp_t;

    exp_t q4[$];
    exp_t q3[$];

    typedef struct {
        logic        en;
        logic        wr;
        logic [1:0]  addr;
        logic [8:0]  mask;
        logic [71:0] data;
        logic [71:0] exp4;
        logic        err4;
        logic [71:0] exp3;
        logic        err3;
    } vec_t;

    dff_ram_bw #(.DEPTH(4), .WIDTH(72), .LANE(8)) u_d4 (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .address(address),
        .wmask(wmask), .wdata(wdata), .clr(clr),
        .rdata(rdata4), .rvalid(rvalid4), .rerr(rerr4), .ready(ready4)
    );

    dff_ram_bw #(.DEPTH(3), .WIDTH(72), .LANE(8)) u_d3 (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .address(address),
        .wmask(wmask), .wdata(wdata), .clr(clr),
        .rdata(rdata3), .rvalid(rvalid3), .rerr(rerr3), .ready(ready3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Scoreboard: every read pushed at drive time must show up exactly one edge later.
    always begin
        exp_t e;
        logic pend;
        @(posedge clk);
        #1;
        pend = (q4.size() > 0);
        check("rvalid4", {71'd0, rvalid4}, {71'd0, pend});
        if (pend) begin
            e = q4.pop_front();
            if (rvalid4) begin
                check("rdata4", rdata4, e.data);
                check("rerr4", {71'd0, rerr4}, {71'd0, e.err});
            end
        end else begin
            check("rerr4_idle", {71'd0, rerr4}, 72'd0);
        end
        pend = (q3.size() > 0);
        check("rvalid3", {71'd0, rvalid3}, {71'd0, pend});
        if (pend) begin
            e = q3.pop_front();
            if (rvalid3) begin
                check("rdata3", rdata3, e.data);
                check("rerr3", {71'd0, rerr3}, {71'd0, e.err});
            end
        end else begin
            check("rerr3_idle", {71'd0, rerr3}, 72'd0);
        end
    end

    task automatic op(input logic e_n, input logic w, input logic [1:0] a, input logic [8:0] m,
                      input logic [71:0] d, input logic [71:0] x4, input logic r4,
                      input logic [71:0] x3, input logic r3);
        exp_t e;
        @(negedge clk);
        en = e_n; wr = w; address = a; wmask = m; wdata = d;
        if (!e_n && w) begin
            e.data = x4; e.err = r4; q4.push_back(e);
            e.data = x3; e.err = r3; q3.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            en = 1'b1; wr = 1'b1; wmask = '0;
        end
    endtask

    // Counts edges until ready rises for each instance; -1 marks a ready that dropped again.
    task automatic measure(input string name, input int exp4, input int exp3);
        int f4 = 0;
        int f3 = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (f4 > 0 && !ready4) f4 = -1;
            if (f3 > 0 && !ready3) f3 = -1;
            if (ready4 && f4 == 0) f4 = k;
            if (ready3 && f3 == 0) f3 = k;
        end
        check({name, "_clr4"}, 72'(f4), 72'(exp4));
        check({name, "_clr3"}, 72'(f3), 72'(exp3));
    endtask

    task automatic read_all_zero();
        for (int a = 0; a < 4; a++) begin
            op(1'b0, 1'b1, 2'(a), 9'h0, 72'h0, 72'h0, 1'b0, 72'h0, (a == 3));
        end
        idle(1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_rdata4"}, rdata4, 72'h0);
        check({name, "_rdata3"}, rdata3, 72'h0);
        check({name, "_ready4"}, {71'd0, ready4}, 72'd0);
        check({name, "_ready3"}, {71'd0, ready3}, 72'd0);
        check({name, "_rv4"}, {71'd0, rvalid4 | rerr4}, 72'd0);
        check({name, "_rv3"}, {71'd0, rvalid3 | rerr3}, 72'd0);
    endtask

    initial begin
        vec_t vecs[$];
        rst = 1'b1; en = 1'b1; wr = 1'b1; address = '0; wmask = '0; wdata = '0; clr = 1'b0;

        vecs = '{
            // masked write then same-address read on the next cycle
            '{1'b0, 1'b0, 2'd2, 9'h1FF, 72'hFF_EEDDCCBB_AA998877, 72'h0, 1'b0, 72'h0, 1'b0},
            '{1'b0, 1'b0, 2'd2, 9'h003, 72'h11_22334455_66778899, 72'h0, 1'b0, 72'h0, 1'b0},
            '{1'b0, 1'b1, 2'd2, 9'h000, 72'h0, 72'hFF_EEDDCCBB_AA998899, 1'b0, 72'hFF_EEDDCCBB_AA998899, 1'b0},
            '{1'b1, 1'b1, 2'd0, 9'h000, 72'h0, 72'h0, 1'b0, 72'h0, 1'b0},
            // address 3: valid word for DEPTH=4, out of range for DEPTH=3
            '{1'b0, 1'b0, 2'd3, 9'h1FF, 72'h5, 72'h0, 1'b0, 72'h0, 1'b0},
            '{1'b0, 1'b1, 2'd3, 9'h000, 72'h0, 72'h5, 1'b0, 72'h0, 1'b1},
            '{1'b0, 1'b1, 2'd0, 9'h000, 72'h0, 72'h0, 1'b0, 72'h0, 1'b0},
            // all-zero mask leaves the word untouched
            '{1'b0, 1'b0, 2'd2, 9'h000, {72{1'b1}}, 72'h0, 1'b0, 72'h0, 1'b0},
            '{1'b0, 1'b1, 2'd2, 9'h000, 72'h0, 72'hFF_EEDDCCBB_AA998899, 1'b0, 72'hFF_EEDDCCBB_AA998899, 1'b0},
            // writes then back-to-back reads
            '{1'b0, 1'b0, 2'd0, 9'h1FF, 72'h1, 72'h0, 1'b0, 72'h0, 1'b0},
            '{1'b0, 1'b0, 2'd1, 9'h1FF, 72'h2, 72'h0, 1'b0, 72'h0, 1'b0},
            '{1'b0, 1'b0, 2'd2, 9'h1FF, 72'h3, 72'h0, 1'b0, 72'h0, 1'b0},
            '{1'b0, 1'b1, 2'd0, 9'h000, 72'h0, 72'h1, 1'b0, 72'h1, 1'b0},
            '{1'b0, 1'b1, 2'd1, 9'h000, 72'h0, 72'h2, 1'b0, 72'h2, 1'b0},
            '{1'b0, 1'b1, 2'd2, 9'h000, 72'h0, 72'h3, 1'b0, 72'h3, 1'b0}
        };

        // Reset state and initial clear length
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        measure("boot", 4, 3);
        read_all_zero();

        // Table-driven access vectors
        foreach (vecs[i]) begin
            op(vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].mask, vecs[i].data,
               vecs[i].exp4, vecs[i].err4, vecs[i].exp3, vecs[i].err3);
        end
        idle(3);
        check("hold4", rdata4, 72'h3);
        check("hold3", rdata3, 72'h3);

        // clr beats a simultaneous write, then a full clear runs
        @(negedge clk);
        clr = 1'b1; en = 1'b0; wr = 1'b0; address = 2'd1; wmask = 9'h1FF; wdata = 72'hA;
        @(negedge clk);
        clr = 1'b0; en = 1'b1; wr = 1'b1; wmask = '0;
        check("clr_ready4", {71'd0, ready4}, 72'd0);
        measure("clr", 4, 3);
        read_all_zero();

        // Reset mid-clear, with reads attempted while clearing
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; en = 1'b0; wr = 1'b1; address = 2'd1;
        repeat (2) @(negedge clk);
        check("midclr_ready4", {71'd0, ready4}, 72'd0);
        rst = 1'b1; en = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        measure("rerun", 4, 3);
        op(1'b0, 1'b0, 2'd1, 9'h1FF, 72'hBEEF, 72'h0, 1'b0, 72'h0, 1'b0);
        op(1'b0, 1'b1, 2'd1, 9'h0, 72'h0, 72'hBEEF, 1'b0, 72'hBEEF, 1'b0);
        idle(3);

        check("q4_drained", 72'(q4.size()), 72'd0);
        check("q3_drained", 72'(q3.size()), 72'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
